// File: rtl/fft8_share_arbiter.sv
// fft8_share_arbiter: round-robin sharing of one FFT core (start/busy/valid handshake)
// between NUM_REQ requesters. The core's sample-data mux is external and is driven by sel_o.
// Optional build macro FFT_ARB_TIMEOUT_EN adds a RUN-state watchdog that reports a
// stuck job on err_o. Without the macro, RUN waits indefinitely and err_o is tied low.
module fft8_share_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned IDX_W       = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned TO_W        = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   sel_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic [NUM_REQ-1:0] err_o,
    output logic               core_start_o,
    input  logic               core_busy_i,
    input  logic               core_valid_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   done_cnt_o
);

    typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

    state_e             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_done;
    logic               r_start;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [NUM_REQ-1:0] w_onehot;

`ifdef FFT_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0] r_err;
    logic [TO_W-1:0]    r_to_cnt;
`endif

    // Round-robin search: first asserted request strictly after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_onehot = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            automatic int unsigned idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_i[idx]) begin
                w_found = 1'b1;
                w_win   = idx[IDX_W-1:0];
            end
        end
        w_onehot[w_win] = 1'b1;
    end

    // Job sequencer with registered outputs: IDLE -> START -> RUN -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_ptr    <= IDX_W'(NUM_REQ - 1);
            r_gnt    <= '0;
            r_sel    <= '0;
            r_done   <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
`ifdef FFT_ARB_TIMEOUT_EN
            r_err    <= '0;
            r_to_cnt <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found && !core_busy_i) begin
                        r_gnt   <= w_onehot;
                        r_sel   <= w_win;
                        r_ptr   <= w_win;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    r_start  <= 1'b0;
`ifdef FFT_ARB_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    r_state  <= StRun;
                end
                StRun: begin
                    // A valid on the same edge as the timeout limit takes precedence.
                    if (core_valid_i) begin
                        r_done  <= r_gnt;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= StDone;
                    end
`ifdef FFT_ARB_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_err   <= r_gnt;
                        r_state <= StDone;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                StDone: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
`ifdef FFT_ARB_TIMEOUT_EN
                    r_err   <= '0;
`endif
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign sel_o        = r_sel;
    assign done_o       = r_done;
    assign core_start_o = r_start;
    assign busy_o       = r_busy;
    assign done_cnt_o   = r_cnt;
`ifdef FFT_ARB_TIMEOUT_EN
    assign err_o        = r_err;
`else
    assign err_o        = '0;
`endif

endmodule
